// File: rtl/scr1_mem_port_arb.sv
// Shares one SCR1-style memory port between the imem and dmem ports.
// Round-robin grant with lock-until-ack; an in-order ID FIFO routes responses back.
package scr1_mem_arb_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_IDLE = 2'b00,
    SCR1_MEM_RESP_RDY  = 2'b01,
    SCR1_MEM_RESP_ER   = 2'b10
  } type_scr1_mem_resp_e;

endpackage

module scr1_mem_port_arb
  import scr1_mem_arb_pkg::*;
#(
  parameter int SCR1_ARB_AWIDTH = 32,
  parameter int SCR1_ARB_DWIDTH = 32,
  parameter int SCR1_ARB_OUTSTD = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       imem_req,
  input  type_scr1_mem_cmd_e         imem_cmd,
  input  logic [SCR1_ARB_AWIDTH-1:0] imem_addr,
  output logic                       imem_req_ack,
  output logic [SCR1_ARB_DWIDTH-1:0] imem_rdata,
  output type_scr1_mem_resp_e        imem_resp,
  input  logic                       dmem_req,
  input  type_scr1_mem_cmd_e         dmem_cmd,
  input  type_scr1_mem_width_e       dmem_width,
  input  logic [SCR1_ARB_AWIDTH-1:0] dmem_addr,
  input  logic [SCR1_ARB_DWIDTH-1:0] dmem_wdata,
  output logic                       dmem_req_ack,
  output logic [SCR1_ARB_DWIDTH-1:0] dmem_rdata,
  output type_scr1_mem_resp_e        dmem_resp,
  output logic                       mem_req,
  output type_scr1_mem_cmd_e         mem_cmd,
  output type_scr1_mem_width_e       mem_width,
  output logic [SCR1_ARB_AWIDTH-1:0] mem_addr,
  output logic [SCR1_ARB_DWIDTH-1:0] mem_wdata,
  input  logic                       mem_req_ack,
  input  logic [SCR1_ARB_DWIDTH-1:0] mem_rdata,
  input  type_scr1_mem_resp_e        mem_resp
);

  localparam int PTR_W = (SCR1_ARB_OUTSTD > 1) ? $clog2(SCR1_ARB_OUTSTD) : 1;
  localparam int CNT_W = $clog2(SCR1_ARB_OUTSTD + 1);
  localparam logic [CNT_W-1:0] OUTSTD_CNT = CNT_W'(SCR1_ARB_OUTSTD);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(SCR1_ARB_OUTSTD - 1);

  typedef enum logic [1:0] {
    ARB_UNLOCKED,
    ARB_LOCKED_I,
    ARB_LOCKED_D
  } arbState_e;

  typedef enum logic {
    PORT_IMEM = 1'b0,
    PORT_DMEM = 1'b1
  } arbPort_e;

  arbState_e        state_q, state_d;
  arbPort_e         rrLast_q, rrLast_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  arbPort_e         idFifo_q [SCR1_ARB_OUTSTD];

  arbPort_e sel;
  arbPort_e headId;
  logic     selReq;
  logic     pop;
  logic     acceptOk;
  logic     accept;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // A response retiring the head frees a slot in the same cycle, so a full FIFO can still accept.
  always_comb begin
    pop      = (mem_resp != SCR1_MEM_RESP_IDLE) && (count_q != '0);
    acceptOk = (count_q < OUTSTD_CNT) || pop;

    sel = PORT_IMEM;
    case (state_q)
      ARB_LOCKED_I: sel = PORT_IMEM;
      ARB_LOCKED_D: sel = PORT_DMEM;
      default: begin
        if (imem_req && dmem_req) begin
          sel = (rrLast_q == PORT_IMEM) ? PORT_DMEM : PORT_IMEM;
        end else if (dmem_req) begin
          sel = PORT_DMEM;
        end
      end
    endcase

    selReq       = (sel == PORT_DMEM) ? dmem_req : imem_req;
    mem_req      = selReq && acceptOk;
    accept       = mem_req && mem_req_ack;
    imem_req_ack = accept && (sel == PORT_IMEM);
    dmem_req_ack = accept && (sel == PORT_DMEM);

    state_d = state_q;
    case (state_q)
      ARB_UNLOCKED: begin
        if (mem_req && !mem_req_ack) begin
          state_d = (sel == PORT_DMEM) ? ARB_LOCKED_D : ARB_LOCKED_I;
        end
      end
      default: begin
        if (accept || !selReq) begin
          state_d = ARB_UNLOCKED;
        end
      end
    endcase

    rrLast_d = accept ? sel : rrLast_q;
    rdPtr_d  = pop ? ptrInc(rdPtr_q) : rdPtr_q;
    wrPtr_d  = accept ? ptrInc(wrPtr_q) : wrPtr_q;
    count_d  = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    mem_cmd   = imem_cmd;
    mem_width = SCR1_MEM_WIDTH_WORD;
    mem_addr  = imem_addr;
    mem_wdata = '0;
    if (sel == PORT_DMEM) begin
      mem_cmd   = dmem_cmd;
      mem_width = dmem_width;
      mem_addr  = dmem_addr;
      mem_wdata = dmem_wdata;
    end
  end

  // Responses with nothing outstanding are dropped rather than routed to a stale head.
  always_comb begin
    headId     = idFifo_q[rdPtr_q];
    imem_resp  = SCR1_MEM_RESP_IDLE;
    imem_rdata = '0;
    dmem_resp  = SCR1_MEM_RESP_IDLE;
    dmem_rdata = '0;
    if (count_q != '0) begin
      if (headId == PORT_DMEM) begin
        dmem_resp  = mem_resp;
        dmem_rdata = mem_rdata;
      end else begin
        imem_resp  = mem_resp;
        imem_rdata = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_UNLOCKED;
      rrLast_q <= PORT_IMEM;
      count_q  <= '0;
      rdPtr_q  <= '0;
      wrPtr_q  <= '0;
      for (int i = 0; i < SCR1_ARB_OUTSTD; i++) begin
        idFifo_q[i] <= PORT_IMEM;
      end
    end else begin
      state_q  <= state_d;
      rrLast_q <= rrLast_d;
      count_q  <= count_d;
      rdPtr_q  <= rdPtr_d;
      wrPtr_q  <= wrPtr_d;
      if (accept) begin
        idFifo_q[wrPtr_q] <= sel;
      end
    end
  end

endmodule

// File: doc/scr1_mem_port_arb.md
Name: scr1_mem_port_arb

Overview:
- Arbiter that shares one SCR1-style memory port between the core instruction port (imem) and data port (dmem).
- Used when imem and dmem sit behind a single memory or bridge.
- Forwards one request per cycle, chosen by round-robin with lock-until-ack.
- Records the requester of each accepted request in an in-order ID FIFO and routes each response back to its originator.

Parameters:
- SCR1_ARB_AWIDTH, 32, address width of all three ports.
- SCR1_ARB_DWIDTH, 32, data width of all three ports.
- SCR1_ARB_OUTSTD, 2, maximum accepted-but-unanswered requests (ID FIFO depth, ≥1).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  in  1  instruction request, held until imem_req_ack
- imem_cmd  in  type_scr1_mem_cmd_e  RD/WR
- imem_addr  in  AWIDTH  instruction address
- imem_req_ack  out  1  imem request accepted this cycle
- imem_rdata  out  DWIDTH  read data to imem
- imem_resp  out  type_scr1_mem_resp_e  IDLE/RDY/ER to imem
- dmem_req  in  1  data request, held until dmem_req_ack
- dmem_cmd  in  type_scr1_mem_cmd_e  RD/WR
- dmem_width  in  type_scr1_mem_width_e  byte/hword/word
- dmem_addr  in  AWIDTH  data address
- dmem_wdata  in  DWIDTH  write data
- dmem_req_ack  out  1  dmem request accepted this cycle
- dmem_rdata  out  DWIDTH  read data to dmem
- dmem_resp  out  type_scr1_mem_resp_e  response to dmem
- mem_req  out  1  shared-port request
- mem_cmd  out  type_scr1_mem_cmd_e  forwarded command
- mem_width  out  type_scr1_mem_width_e  forwarded width; WORD for imem
- mem_addr  out  AWIDTH  forwarded address
- mem_wdata  out  DWIDTH  forwarded write data; 0 for imem
- mem_req_ack  in  1  shared port accepted request
- mem_rdata  in  DWIDTH  shared-port read data
- mem_resp  in  type_scr1_mem_resp_e  shared-port response, in request order

Behaviour:
- Reset (async assert, sync deassert by the surrounding reset logic) clears the following:
  - FIFO empty (count=0, rd/wr ptr=0).
  - Lock state UNLOCKED.
  - rr_last=IMEM, so dmem wins the first tie.
  - All outputs combinational; with all inputs idle after reset: mem_req=0, both req_acks=0, both resp=IDLE, rdata=0.
- accept_ok = (count < OUTSTD) | pop, where pop = (mem_resp != IDLE) & (count != 0).
- Lock FSM:
  - UNLOCKED: sel is the single requester if only one is active. If both are active, sel is the requester other than rr_last. mem_req = selected req & accept_ok.
  - If mem_req=1 & mem_req_ack=0: go to LOCKED_I or LOCKED_D per sel.
  - LOCKED_x: sel forced to x; mem_req = x_req & accept_ok. Return to UNLOCKED on mem_req_ack, or if x_req drops (protocol violation, tolerated).
- mem_cmd/width/addr/wdata are muxed from sel. They must not change while locked.
- Accept: mem_req & mem_req_ack.
  - Pulses x_req_ack for sel in the same cycle.
  - Pushes sel ID into FIFO.
  - Sets rr_last=sel.
- Response:
  - When count!=0, head ID routes mem_resp/mem_rdata to that requester; the other port sees resp=IDLE, rdata=0.
  - Any non-IDLE response (RDY or ER) pops the head.
  - Simultaneous push and pop: count unchanged, pointers both advance; allowed even when full.
  - Zero-latency response: a response in the same cycle as its own accept is not supported. The earliest response is the cycle after accept.
- Non-IDLE mem_resp with count=0 is discarded: not forwarded, no pointer change.
- Pointers wrap modulo OUTSTD. count width is clog2(OUTSTD+1).
- Full (count=OUTSTD, no pop): mem_req=0, no acks; requesters keep req asserted.
- Reset mid-transaction drops outstanding IDs. Late responses after reset fall under the count=0 discard rule.

Test Plan:
- Single imem read: imem_req, addr=0x200, ack next cycle, RDY with rdata=0xDEADBEEF two cycles later.
  -> mem_width=WORD, imem_req_ack pulses 1 cycle, imem_resp=RDY, imem_rdata=0xDEADBEEF, dmem_resp stays IDLE.
- Both requesting continuously, mem_req_ack=1 always, responses every cycle.
  -> grants alternate D,I,D,I starting with dmem; 4 responses routed in order D,I,D,I.
- dmem write at 0x1000 width HWORD, mem_req_ack held 0 for 3 cycles while imem_req rises.
  -> mem_addr stays 0x1000 for all 4 cycles; imem granted only after the dmem ack.
- OUTSTD=2: accept 2 imem reads, withhold responses.
  -> third request sees mem_req=0. Issue RDY in cycle N: third request is accepted in cycle N (push+pop), count stays 2.
- ER response for a dmem read.
  -> dmem_resp=ER, FIFO pops, next RDY goes to the next queued requester.
- Assert rst_n=0 with 2 outstanding, release, then drive mem_resp=RDY.
  -> outputs reset immediately, response discarded, both resp=IDLE, count=0.
